// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg -- shared types and constants for the pipeline hazard controller.
//
// Contents:
//   hc_state_e    : controller state (RUN / MEMWAIT)
//   PCSRC_*       : encodings of the PC select output
//   MEM_TIMEOUT   : wait-counter value at which an unanswered memory access
//                   is abandoned
//   hc_ctrl_t     : bundle of all decoded control outputs
//   load_use_hit  : load-use hazard detection between ID and ID/EX
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } hc_state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [3:0] MEM_TIMEOUT = 4'd15;

    typedef struct packed {
        logic       pc_write;
        logic       bf1_write;
        logic       bf1_flush;
        logic       bf2_flush;
        logic       bf3_flush;
        logic       freeze;
        logic [1:0] pc_src;
        logic       mem_req;
        logic       mem_err;
    } hc_ctrl_t;

    // A load in EX whose destination feeds a source of the ID instruction.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (dest != 5'd0) &&
               ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/hc_sat_counter.sv
// -----------------------------------------------------------------------------
// hc_sat_counter -- up-counter that sticks at its maximum value.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count
//   en     in   increment enable
//   count  out  current count (WIDTH bits, saturates at all-ones)
// -----------------------------------------------------------------------------
module hc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- hazard and memory-wait controller for a 5-stage pipeline.
//
// Handles control redirects (taken branch / jump resolved in MEM), load-use
// stalls between ID and EX, and stalls on a slow data memory with a timeout.
// Outputs are decoded combinationally from the state and current inputs.
//
// Ports:
//   clk_HC, rst_n_HC            clock, async active-low reset
//   rs_ID, rt_ID, usesRt_ID     ID-stage source registers / rt usage
//   MemRead_EX, rtDest_EX       load flag and destination in ID/EX
//   branch_MEM, zf_MEM, jump_MEM, MemRead_MEM, MemWrite_MEM
//                               EX/MEM control bits
//   mem_ack                     data memory completion
//   pcWrite_HC, bf1Write_HC     PC and IF/ID load enables
//   bf1Flush_HC..bf3Flush_HC    clear control bits of IF/ID, ID/EX, EX/MEM
//   freeze_HC                   hold every pipeline buffer and the PC
//   pcSrc_HC                    PC select (PCSRC_SEQ / PCSRC_BR / PCSRC_JMP)
//   mem_req_HC, memErr_HC       memory request, one-cycle timeout pulse
//   stallCnt_HC, flushCnt_HC    (only with HC_STATS_EN) saturating counts of
//                               stall cycles and redirect cycles
//
// Build option: define HC_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk_HC,
    input  logic       rst_n_HC,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       usesRt_ID,
    input  logic       MemRead_EX,
    input  logic [4:0] rtDest_EX,
    input  logic       branch_MEM,
    input  logic       zf_MEM,
    input  logic       jump_MEM,
    input  logic       MemRead_MEM,
    input  logic       MemWrite_MEM,
    input  logic       mem_ack,
    output logic       pcWrite_HC,
    output logic       bf1Write_HC,
    output logic       bf1Flush_HC,
    output logic       bf2Flush_HC,
    output logic       bf3Flush_HC,
    output logic       freeze_HC,
    output logic [1:0] pcSrc_HC,
    output logic       mem_req_HC,
    output logic       memErr_HC
`ifdef HC_STATS_EN
    ,
    output logic [15:0] stallCnt_HC,
    output logic [15:0] flushCnt_HC
`endif
);

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release follows clk_HC.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk_HC or negedge rst_n_HC) begin
        if (!rst_n_HC) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State and wait counter
    // ------------------------------------------------------------------
    hc_state_e  state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk_HC or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic     redirect;
    logic     mem_access;
    logic     load_use;
    logic     mem_stall;
    hc_ctrl_t ctrl;

    assign redirect   = (branch_MEM && zf_MEM) || jump_MEM;
    assign mem_access = MemRead_MEM || MemWrite_MEM;
    assign load_use   = load_use_hit(MemRead_EX, rtDest_EX, rs_ID, rt_ID, usesRt_ID);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        ctrl           = '0;
        ctrl.pc_write  = 1'b1;
        ctrl.bf1_write = 1'b1;
        ctrl.pc_src    = PCSRC_SEQ;
        mem_stall      = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Redirect flushes the wrong-path instructions and also
                    // cancels whatever memory access sits in EX/MEM.
                    ctrl.pc_src    = jump_MEM ? PCSRC_JMP : PCSRC_BR;
                    ctrl.bf1_flush = 1'b1;
                    ctrl.bf2_flush = 1'b1;
                    ctrl.bf3_flush = 1'b1;
                end else if (mem_access) begin
                    ctrl.mem_req = 1'b1;
                    if (!mem_ack) begin
                        mem_stall  = 1'b1;
                        state_d    = ST_MEMWAIT;
                        wait_cnt_d = '0;
                    end
                end
            end

            ST_MEMWAIT: begin
                // The pipeline is frozen here, so EX/MEM still holds the
                // memory instruction and no redirect can be pending.
                ctrl.mem_req = 1'b1;
                if (mem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MEM_TIMEOUT) begin
                    ctrl.mem_req = 1'b0;
                    ctrl.mem_err = 1'b1;
                    state_d      = ST_RUN;
                    wait_cnt_d   = '0;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // A memory freeze outranks a load-use stall. Once the freeze is
        // released the dependent instruction is still in ID, so the
        // load-use bubble is inserted in that same release cycle.
        if (mem_stall) begin
            ctrl.freeze    = 1'b1;
            ctrl.pc_write  = 1'b0;
            ctrl.bf1_write = 1'b0;
        end else if (load_use && !ctrl.bf3_flush) begin
            ctrl.pc_write  = 1'b0;
            ctrl.bf1_write = 1'b0;
            ctrl.bf2_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: forced to zero for as long as the raw reset is low.
    // ------------------------------------------------------------------
    assign pcWrite_HC  = rst_n_HC & ctrl.pc_write;
    assign bf1Write_HC = rst_n_HC & ctrl.bf1_write;
    assign bf1Flush_HC = rst_n_HC & ctrl.bf1_flush;
    assign bf2Flush_HC = rst_n_HC & ctrl.bf2_flush;
    assign bf3Flush_HC = rst_n_HC & ctrl.bf3_flush;
    assign freeze_HC   = rst_n_HC & ctrl.freeze;
    assign pcSrc_HC    = rst_n_HC ? ctrl.pc_src : PCSRC_SEQ;
    assign mem_req_HC  = rst_n_HC & ctrl.mem_req;
    assign memErr_HC   = rst_n_HC & ctrl.mem_err;

`ifdef HC_STATS_EN
    // bf3Flush is raised only by a redirect, so it marks redirect cycles.
    hc_sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk_HC),
        .rst_n (rst_sync_n),
        .en    (~ctrl.pc_write),
        .count (stallCnt_HC)
    );

    hc_sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk_HC),
        .rst_n (rst_sync_n),
        .en    (ctrl.bf3_flush),
        .count (flushCnt_HC)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
//
// A behavioural model tracks only "is a memory request outstanding" and "how
// many freeze cycles it has used" (at most 16 before it is abandoned) and
// derives every output from the hazard rules. Directed scenarios pin the
// model with literal expectations, then randomised traffic runs against it.
// Define HC_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk_HC = 1'b0;
    logic       rst_n_HC;
    logic [4:0] rs_ID, rt_ID, rtDest_EX;
    logic       usesRt_ID, MemRead_EX;
    logic       branch_MEM, zf_MEM, jump_MEM, MemRead_MEM, MemWrite_MEM, mem_ack;
    logic       pcWrite_HC, bf1Write_HC, bf1Flush_HC, bf2Flush_HC, bf3Flush_HC;
    logic       freeze_HC, mem_req_HC, memErr_HC;
    logic [1:0] pcSrc_HC;
`ifdef HC_STATS_EN
    logic [15:0] stallCnt_HC, flushCnt_HC;
`endif

    always #5 clk_HC = ~clk_HC;

    hazard_ctrl dut (
        .clk_HC       (clk_HC),
        .rst_n_HC     (rst_n_HC),
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .usesRt_ID    (usesRt_ID),
        .MemRead_EX   (MemRead_EX),
        .rtDest_EX    (rtDest_EX),
        .branch_MEM   (branch_MEM),
        .zf_MEM       (zf_MEM),
        .jump_MEM     (jump_MEM),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .mem_ack      (mem_ack),
        .pcWrite_HC   (pcWrite_HC),
        .bf1Write_HC  (bf1Write_HC),
        .bf1Flush_HC  (bf1Flush_HC),
        .bf2Flush_HC  (bf2Flush_HC),
        .bf3Flush_HC  (bf3Flush_HC),
        .freeze_HC    (freeze_HC),
        .pcSrc_HC     (pcSrc_HC),
        .mem_req_HC   (mem_req_HC),
        .memErr_HC    (memErr_HC)
`ifdef HC_STATS_EN
        ,
        .stallCnt_HC  (stallCnt_HC),
        .flushCnt_HC  (flushCnt_HC)
`endif
    );

    typedef struct packed {
        logic       br, zf, jmp, mrm, mwm, ack, mr_ex, ut;
        logic [4:0] rs, rt, rd;
    } stim_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit m_waiting;
    int m_frozen;   // freeze cycles already spent on the outstanding request
    int m_stall;
    int m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {pcWrite, bf1Write, bf1Flush, bf2Flush, bf3Flush, freeze, pcSrc, mem_req, memErr}
    function automatic logic [9:0] got_vec();
        return {pcWrite_HC, bf1Write_HC, bf1Flush_HC, bf2Flush_HC, bf3Flush_HC,
                freeze_HC, pcSrc_HC, mem_req_HC, memErr_HC};
    endfunction

    task automatic model_reset();
        m_waiting = 1'b0;
        m_frozen  = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic drive(input stim_t s);
        branch_MEM   = s.br;
        zf_MEM       = s.zf;
        jump_MEM     = s.jmp;
        MemRead_MEM  = s.mrm;
        MemWrite_MEM = s.mwm;
        mem_ack      = s.ack;
        MemRead_EX   = s.mr_ex;
        usesRt_ID    = s.ut;
        rs_ID        = s.rs;
        rt_ID        = s.rt;
        rtDest_EX    = s.rd;
    endtask

    // One clock cycle: drive after the falling edge, compare the settled
    // combinational outputs against the model, then advance the model to
    // the state it will hold after the next rising edge.
    task automatic step(input stim_t s);
        bit         redirect, lu, holding;
        logic       pcw, b1w, f1, f2, f3, frz, req, err;
        logic [1:0] src;
        @(negedge clk_HC);
        drive(s);
        #1;
`ifdef HC_STATS_EN
        check("stallCnt", 32'(stallCnt_HC), 32'(m_stall));
        check("flushCnt", 32'(flushCnt_HC), 32'(m_flush));
`endif
        redirect = (s.br && s.zf) || s.jmp;
        lu = s.mr_ex && (s.rd != 5'd0) && ((s.rd == s.rs) || (s.ut && (s.rd == s.rt)));
        pcw = 1'b1; b1w = 1'b1; f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
        frz = 1'b0; req = 1'b0; err = 1'b0; src = 2'd0; holding = 1'b0;
        if (!m_waiting && redirect) begin
            src = s.jmp ? 2'd2 : 2'd1;
            f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
        end else begin
            if (m_waiting || s.mrm || s.mwm) begin
                req = 1'b1;
                if (s.ack) begin
                    m_waiting = 1'b0; m_frozen = 0;
                end else if (m_frozen == 16) begin
                    req = 1'b0; err = 1'b1;
                    m_waiting = 1'b0; m_frozen = 0;
                end else begin
                    holding = 1'b1;
                    m_waiting = 1'b1; m_frozen++;
                end
            end
            if (holding) begin
                frz = 1'b1; pcw = 1'b0; b1w = 1'b0;
            end else if (lu) begin
                pcw = 1'b0; b1w = 1'b0; f2 = 1'b1;
            end
        end
        check("ctrl_vec", 32'(got_vec()), 32'({pcw, b1w, f1, f2, f3, frz, src, req, err}));
        if (!pcw && m_stall < 16'hFFFF) m_stall++;
        if (f3 && m_flush < 16'hFFFF) m_flush++;
    endtask

    task automatic do_reset();
        @(negedge clk_HC);
        rst_n_HC = 1'b0;
        drive('0);
        #1;
        check("reset_outputs_zero", 32'(got_vec()), 32'd0);
        model_reset();
        repeat (2) @(negedge clk_HC);
        rst_n_HC = 1'b1;
        // Let the synchronised reset release with idle inputs.
        repeat (3) step('0);
    endtask

    stim_t s;
    int    frz_cnt, err_cnt;

    initial begin
        rst_n_HC = 1'b0;
        drive('0);
        model_reset();
        do_reset();

        // Load-use: rs matches load destination -> one bubble
        s = '0; s.mr_ex = 1'b1; s.rd = 5'd5; s.rs = 5'd5;
        step(s);
        check("lu_pcWrite", 32'(pcWrite_HC), 32'd0);
        check("lu_bf1Write", 32'(bf1Write_HC), 32'd0);
        check("lu_bf2Flush", 32'(bf2Flush_HC), 32'd1);
        check("lu_bf1Flush", 32'(bf1Flush_HC), 32'd0);
        step('0);
        check("lu_after_pcWrite", 32'(pcWrite_HC), 32'd1);
        s = '0; s.mr_ex = 1'b1; s.rd = 5'd0; s.rs = 5'd0;
        step(s);
        check("lu_r0_pcWrite", 32'(pcWrite_HC), 32'd1);
        check("lu_r0_bf2Flush", 32'(bf2Flush_HC), 32'd0);
        // rt dependency only counts when rt is used
        s = '0; s.mr_ex = 1'b1; s.rd = 5'd7; s.rt = 5'd7; s.rs = 5'd1; s.ut = 1'b0;
        step(s);
        check("lu_rt_unused_pcWrite", 32'(pcWrite_HC), 32'd1);
        s.ut = 1'b1;
        step(s);
        check("lu_rt_used_pcWrite", 32'(pcWrite_HC), 32'd0);

        // Branch taken / not taken
        s = '0; s.br = 1'b1; s.zf = 1'b1;
        step(s);
        check("br_pcSrc", 32'(pcSrc_HC), 32'd1);
        check("br_flushes", 32'({bf1Flush_HC, bf2Flush_HC, bf3Flush_HC}), 32'h7);
        s.zf = 1'b0;
        step(s);
        check("br_nt_flushes", 32'({bf1Flush_HC, bf2Flush_HC, bf3Flush_HC}), 32'h0);
        check("br_nt_pcSrc", 32'(pcSrc_HC), 32'd0);

        // Jump together with a load-use and a taken branch: jump wins, no stall
        s = '0; s.jmp = 1'b1; s.br = 1'b1; s.zf = 1'b1; s.mr_ex = 1'b1; s.rd = 5'd3; s.rs = 5'd3;
        step(s);
        check("jmp_pcSrc", 32'(pcSrc_HC), 32'd2);
        check("jmp_pcWrite", 32'(pcWrite_HC), 32'd1);
        check("jmp_flushes", 32'({bf1Flush_HC, bf2Flush_HC, bf3Flush_HC}), 32'h7);
        // Redirect suppresses a memory request in EX/MEM
        s = '0; s.jmp = 1'b1; s.mrm = 1'b1;
        step(s);
        check("jmp_mem_req", 32'(mem_req_HC), 32'd0);

        // Load with ack arriving in the fourth cycle
        frz_cnt = 0; err_cnt = 0;
        s = '0; s.mrm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s.ack = (i == 3);
            step(s);
            frz_cnt += int'(freeze_HC);
            err_cnt += int'(memErr_HC);
        end
        check("ack_freeze_cycles", 32'(frz_cnt), 32'd3);
        check("ack_cycle_freeze", 32'(freeze_HC), 32'd0);
        check("ack_no_err", 32'(err_cnt), 32'd0);
        step('0);

        // Store that is never acknowledged -> timeout
        frz_cnt = 0; err_cnt = 0;
        s = '0; s.mwm = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(s);
            frz_cnt += int'(freeze_HC);
            err_cnt += int'(memErr_HC);
        end
        check("to_freeze_cycles", 32'(frz_cnt), 32'd16);
        check("to_err_pulses", 32'(err_cnt), 32'd1);
        check("to_mem_req_dropped", 32'(mem_req_HC), 32'd0);
        check("to_freeze_released", 32'(freeze_HC), 32'd0);
        step('0);
        check("to_err_one_cycle", 32'(memErr_HC), 32'd0);
        // Back in RUN: an acknowledged access does not stall
        s = '0; s.mrm = 1'b1; s.ack = 1'b1;
        step(s);
        check("to_run_freeze", 32'(freeze_HC), 32'd0);
        // mem_ack with no request is ignored
        s = '0; s.ack = 1'b1;
        step(s);
        check("stray_ack_req", 32'(mem_req_HC), 32'd0);

        // Reset during the second MEMWAIT cycle
        s = '0; s.mrm = 1'b1;
        repeat (3) step(s);
        #1;
        rst_n_HC = 1'b0;
        #1;
        check("midwait_reset_outputs", 32'(got_vec()), 32'd0);
        @(negedge clk_HC);
        rst_n_HC = 1'b1;
        do_reset();
`ifdef HC_STATS_EN
        check("rst_stallCnt_zero", 32'(stallCnt_HC), 32'd0);
`endif
        // The wait counter restarted from zero: full 16-cycle freeze again
        frz_cnt = 0; err_cnt = 0;
        s = '0; s.mwm = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(s);
            frz_cnt += int'(freeze_HC);
            err_cnt += int'(memErr_HC);
        end
        check("rst_to_freeze_cycles", 32'(frz_cnt), 32'd16);
        check("rst_to_err_pulses", 32'(err_cnt), 32'd1);
        step('0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            s = '0;
            if (!m_waiting) begin
                s.br  = ($urandom_range(0, 7) == 0);
                s.zf  = 1'($urandom_range(0, 1));
                s.jmp = ($urandom_range(0, 15) == 0);
            end
            s.mrm   = ($urandom_range(0, 9) == 0);
            s.mwm   = ($urandom_range(0, 11) == 0);
            s.ack   = ($urandom_range(0, 3) == 0);
            s.mr_ex = ($urandom_range(0, 2) == 0);
            s.ut    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 3));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
